// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between the instruction-fetch port
// and the mem-stage data port. One access at a time, mem has priority over
// fetch, and SRAM controls are held for WAIT_CYCLES+1 cycles per access.
//
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   if_*                fetch port: ce/addr in, rdata/ready/stall out
//   mem_*               data port: ce/addr/we/wdata in, rdata/ready/stall out
//   sram_*              SRAM side: registered ce/addr/we/data out, read data in
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1,   // extra SRAM cycles beyond the first, 0..15
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ready_o,
  output logic              stall_if_o,
  input  logic              mem_ce_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_we_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_ready_o,
  output logic              stall_mem_o,
  output logic              sram_ce_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_we_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_IF, PORT_MEM} port_t;

  // Latched SRAM request; the only thing that drives the SRAM pins.
  typedef struct packed {
    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        we;
    logic [31:0]       data;
  } sram_req_t;

  state_t    state, state_nxt;
  port_t     grant, grant_nxt;
  logic [3:0] cnt, cnt_nxt;
  sram_req_t req_q;
  logic      take_mem, take_if, finish;
  logic      mem_elig, if_elig;

  // A port whose ready pulse is high this cycle is consuming its result, so
  // it cannot be re-granted now; this is what lets a waiting fetch in after
  // every mem access.
  assign mem_elig = mem_ce_i & ~mem_ready_o;
  assign if_elig  = if_ce_i  & ~if_ready_o;

  assign stall_if_o  = if_ce_i  & ~if_ready_o;
  assign stall_mem_o = mem_ce_i & ~mem_ready_o;

  assign sram_ce_o   = req_q.ce;
  assign sram_addr_o = req_q.addr;
  assign sram_we_o   = req_q.we;
  assign sram_data_o = req_q.data;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    take_mem  = 1'b0;
    take_if   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_elig) begin
          take_mem  = 1'b1;
          grant_nxt = PORT_MEM;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = ACCESS;
        end else if (if_elig) begin
          take_if   = 1'b1;
          grant_nxt = PORT_IF;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= PORT_IF;
      cnt         <= '0;
      req_q       <= '0;
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      cnt         <= cnt_nxt;
      if_ready_o  <= finish & (grant == PORT_IF);
      mem_ready_o <= finish & (grant == PORT_MEM);
      if (take_mem || take_if) begin
        req_q.ce   <= 1'b1;
        req_q.addr <= take_mem ? mem_addr_i : if_addr_i;
        req_q.we   <= take_mem ? mem_we_i : 4'b0000;
        req_q.data <= mem_wdata_i;
      end else if (finish) begin
        // Address/data stay put; only the strobes drop.
        req_q.ce <= 1'b0;
        req_q.we <= 4'b0000;
        if (req_q.we == 4'b0000) begin
          if (grant == PORT_MEM) mem_rdata_o <= sram_data_i;
          else                   if_rdata_o  <= sram_data_i;
        end
      end
    end
  end

endmodule
